// File: rtl/gamma_sequencer.sv
// Gamma-window sequencer: clears the column datapath, runs a fixed-length window,
// captures the first (lowest-index) spike and reports it with a valid/ready handshake.
//
// state  | meaning
// IDLE   | datapath held in reset, waiting for start
// CLEAR  | datapath held in reset for RST_CYCLES, capture registers cleared
// RUN    | window running, t counts 0..GAMMA_LEN-1, first spike captured
// REPORT | result presented until win_valid & win_ready
module gamma_sequencer #(
  parameter int NEURONS    = 8,
  parameter int GAMMA_LEN  = 16,
  parameter int RST_CYCLES = 1,
  localparam int IW  = (NEURONS > 1) ? $clog2(NEURONS) : 1,
  localparam int TW  = (GAMMA_LEN > 1) ? $clog2(GAMMA_LEN) : 1,
  localparam int RCW = $clog2(RST_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic [NEURONS-1:0] in_spikes,
  output logic               gamma_rst,
  output logic               busy,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [IW-1:0]      win_idx,
  output logic [TW-1:0]      win_time,
  output logic               win_tie,
  output logic               win_none,
  output logic [15:0]        gamma_cnt
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, REPORT} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      t_q, t_d;
  logic [RCW-1:0]     rc_q, rc_d;
  logic               captured_q, captured_d;
  logic [IW-1:0]      win_idx_q, win_idx_d;
  logic [TW-1:0]      win_time_q, win_time_d;
  logic               win_tie_q, win_tie_d;
  logic               win_none_q, win_none_d;
  logic [15:0]        gamma_cnt_q, gamma_cnt_d;
  logic               gamma_rst_q, gamma_rst_d;
  logic               busy_q, busy_d;
  logic               win_valid_q, win_valid_d;

  logic [NEURONS-1:0] hit;
  logic               hit_any;
  logic               hit_multi;
  logic [IW-1:0]      first_idx;

  always_comb begin
    hit       = ~in_spikes;
    hit_any   = |hit;
    // clearing the lowest set bit leaves something only if two or more lines fired
    hit_multi = (hit & (hit - NEURONS'(1))) != '0;
    first_idx = '0;
    for (int i = NEURONS - 1; i >= 0; i--) begin
      if (hit[i]) first_idx = IW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    rc_d        = rc_q;
    captured_d  = captured_q;
    win_idx_d   = win_idx_q;
    win_time_d  = win_time_q;
    win_tie_d   = win_tie_q;
    win_none_d  = win_none_q;
    gamma_cnt_d = gamma_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          rc_d    = RCW'(RST_CYCLES - 1);
        end
      end
      CLEAR: begin
        captured_d = 1'b0;
        win_idx_d  = '0;
        win_time_d = '0;
        win_tie_d  = 1'b0;
        win_none_d = 1'b0;
        t_d        = '0;
        if (rc_q == '0) state_d = RUN;
        else            rc_d    = rc_q - RCW'(1);
      end
      RUN: begin
        if (!captured_q && hit_any) begin
          captured_d = 1'b1;
          win_idx_d  = first_idx;
          win_time_d = t_q;
          win_tie_d  = hit_multi;
        end
        if (t_q == TW'(GAMMA_LEN - 1)) begin
          state_d    = REPORT;
          win_none_d = !(captured_q || hit_any);
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      REPORT: begin
        if (win_ready) begin
          gamma_cnt_d = gamma_cnt_q + 16'd1;
          if (cont) begin
            state_d = CLEAR;
            rc_d    = RCW'(RST_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    gamma_rst_d = (state_d == IDLE) || (state_d == CLEAR);
    busy_d      = (state_d != IDLE);
    win_valid_d = (state_d == REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      rc_q        <= '0;
      captured_q  <= 1'b0;
      win_idx_q   <= '0;
      win_time_q  <= '0;
      win_tie_q   <= 1'b0;
      win_none_q  <= 1'b0;
      gamma_cnt_q <= '0;
      gamma_rst_q <= 1'b1;
      busy_q      <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      rc_q        <= rc_d;
      captured_q  <= captured_d;
      win_idx_q   <= win_idx_d;
      win_time_q  <= win_time_d;
      win_tie_q   <= win_tie_d;
      win_none_q  <= win_none_d;
      gamma_cnt_q <= gamma_cnt_d;
      gamma_rst_q <= gamma_rst_d;
      busy_q      <= busy_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign gamma_rst = gamma_rst_q;
  assign busy      = busy_q;
  assign win_valid = win_valid_q;
  assign win_idx   = win_idx_q;
  assign win_time  = win_time_q;
  assign win_tie   = win_tie_q;
  assign win_none  = win_none_q;
  assign gamma_cnt = gamma_cnt_q;

endmodule

// File: tb/tb_gamma_sequencer.sv
// Directed bench for gamma_sequencer (NEURONS=8, GAMMA_LEN=16, RST_CYCLES=1):
// reset, single winner, tie, no spike, backpressure/continue, last-cycle capture, mid-window reset.
module tb_gamma_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, cont, win_ready;
  logic [7:0]  in_spikes;
  logic        gamma_rst, busy, win_valid, win_tie, win_none;
  logic [2:0]  win_idx;
  logic [3:0]  win_time;
  logic [15:0] gamma_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_cnt  = 0;
  logic [7:0]  pat [16];

  gamma_sequencer #(.NEURONS(8), .GAMMA_LEN(16), .RST_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cont      (cont),
    .in_spikes (in_spikes),
    .gamma_rst (gamma_rst),
    .busy      (busy),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_idx   (win_idx),
    .win_time  (win_time),
    .win_tie   (win_tie),
    .win_none  (win_none),
    .gamma_cnt (gamma_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic fill_pat(input logic [7:0] v);
    for (int i = 0; i < 16; i++) pat[i] = v;
  endtask

  // Samples start in the current cycle, checks the CLEAR cycle, ends in RUN t=0.
  task automatic start_window(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_clr_busy"}, busy, 1);
    chk({tag, "_clr_grst"}, gamma_rst, 1);
    chk({tag, "_clr_valid"}, win_valid, 0);
    step();
  endtask

  // Drives pat[] over the 16 RUN cycles, then checks the REPORT contents.
  task automatic run_window(input string tag, input logic [2:0] e_idx, input logic [3:0] e_time,
                            input logic e_tie, input logic e_none, input logic noise);
    for (int t = 0; t < 16; t++) begin
      in_spikes = pat[t];
      start     = noise;
      win_ready = noise;
      chk({tag, "_run_valid"}, win_valid, 0);
      if (t == 0) begin
        chk({tag, "_run_grst"}, gamma_rst, 0);
        chk({tag, "_run_busy"}, busy, 1);
      end
      step();
    end
    start     = 1'b0;
    win_ready = 1'b0;
    in_spikes = 8'hFF;
    chk({tag, "_rep_valid"}, win_valid, 1);
    chk({tag, "_rep_grst"}, gamma_rst, 0);
    chk({tag, "_rep_idx"}, win_idx, e_idx);
    chk({tag, "_rep_time"}, win_time, e_time);
    chk({tag, "_rep_tie"}, win_tie, e_tie);
    chk({tag, "_rep_none"}, win_none, e_none);
  endtask

  task automatic handshake(input string tag, input logic c);
    win_ready = 1'b1;
    cont      = c;
    step();
    win_ready = 1'b0;
    cont      = 1'b0;
    exp_cnt++;
    chk({tag, "_hs_cnt"}, gamma_cnt, exp_cnt);
    chk({tag, "_hs_valid"}, win_valid, 0);
    chk({tag, "_hs_grst"}, gamma_rst, 1);
    chk({tag, "_hs_busy"}, busy, c);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    cont      = 1'b0;
    win_ready = 1'b0;
    in_spikes = 8'hFF;
    step();
    step();
    chk("reset_grst", gamma_rst, 1);
    chk("reset_busy", busy, 0);
    chk("reset_valid", win_valid, 0);
    chk("reset_idx", win_idx, 0);
    chk("reset_time", win_time, 0);
    chk("reset_tie", win_tie, 0);
    chk("reset_none", win_none, 0);
    chk("reset_cnt", gamma_cnt, 0);
    rst = 1'b0;
    step();
    chk("idle_grst", gamma_rst, 1);
    chk("idle_busy", busy, 0);

    // single winner, later lines going low are ignored
    fill_pat(8'h00);
    for (int i = 0; i < 3; i++) pat[i] = 8'hFF;
    for (int i = 3; i < 6; i++) pat[i] = 8'hFB;
    start_window("single");
    run_window("single", 3'd2, 4'd3, 1'b0, 1'b0, 1'b0);
    handshake("single", 1'b0);

    // tie at t=0, with start/win_ready toggled during RUN
    fill_pat(8'hFF);
    pat[0] = 8'hDD;
    pat[2] = 8'hFE;
    start_window("tie");
    run_window("tie", 3'd1, 4'd0, 1'b1, 1'b0, 1'b1);
    handshake("tie", 1'b0);

    // no spike, then backpressure and continue
    fill_pat(8'hFF);
    start_window("none");
    run_window("none", 3'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", win_valid, 1);
      chk("bp_none", win_none, 1);
      chk("bp_idx", win_idx, 0);
      chk("bp_time", win_time, 0);
      chk("bp_cnt", gamma_cnt, exp_cnt);
    end
    handshake("cont", 1'b1);
    step();

    // continued window straight from CLEAR, spike only on the last RUN cycle
    fill_pat(8'hFF);
    pat[15] = 8'h7F;
    run_window("last", 3'd7, 4'd15, 1'b0, 1'b0, 1'b0);
    handshake("last", 1'b0);

    // reset at RUN t=7 after a capture at t=2
    fill_pat(8'hFF);
    pat[2] = 8'h00;
    start_window("midrst");
    for (int t = 0; t < 7; t++) begin
      in_spikes = pat[t];
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_spikes = 8'hFF;
    exp_cnt = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_grst", gamma_rst, 1);
    chk("midrst_valid", win_valid, 0);
    chk("midrst_cnt", gamma_cnt, 0);
    chk("midrst_idx", win_idx, 0);
    chk("midrst_tie", win_tie, 0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("midrst_quiet_valid", win_valid, 0);
      chk("midrst_quiet_busy", busy, 0);
    end

    // recovery window after reset
    fill_pat(8'hFF);
    pat[5] = 8'hEF;
    start_window("recover");
    run_window("recover", 3'd4, 4'd5, 1'b0, 1'b0, 1'b0);
    handshake("recover", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
